// File: rtl/vga_fb_arbiter.sv
// rtl/vga_fb_arbiter.sv - double-buffered frame memory arbiter: display reads, FIFO-drained writes, vsync-aligned swap
module vga_fb_arbiter #(
    parameter int H_VALID       = 640,
    parameter int V_VALID       = 480,
    parameter int WR_FIFO_DEPTH = 4
) (
    input  logic        vga_clk,
    input  logic        sys_rst,
    input  logic [10:0] pix_x,
    input  logic [10:0] pix_y,
    input  logic        vsync,
    output logic [15:0] pix_data,
    input  logic        wr_valid,
    output logic        wr_ready,
    input  logic [9:0]  wr_x,
    input  logic [8:0]  wr_y,
    input  logic [15:0] wr_data,
    input  logic        swap_req,
    output logic        swap_pending,
    output logic        swap_done,
    output logic        front_sel,
    output logic        mem_en,
    output logic        mem_we,
    output logic [19:0] mem_addr,
    output logic [15:0] mem_wdata,
    input  logic [15:0] mem_rdata
);

    localparam int PW = $clog2(WR_FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [10:0] PIX_H_LIM = 11'(H_VALID);
    localparam logic [10:0] PIX_V_LIM = 11'(V_VALID);
    localparam logic [9:0]  WR_H_LIM  = 10'(H_VALID);
    localparam logic [8:0]  WR_V_LIM  = 9'(V_VALID);

    typedef enum logic {
        SWAP_IDLE,
        SWAP_PENDING
    } swap_state_t;

    swap_state_t state, state_nxt;

    logic          disp_req;
    logic          rd_flag;
    logic          vsync_d;
    logic          vs_rise;
    logic          swap_fire;
    logic [34:0]   fifo_mem [WR_FIFO_DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          fifo_empty;
    logic          push;
    logic          pop;
    logic [9:0]    head_x;
    logic [8:0]    head_y;
    logic [15:0]   head_data;

    // y*640 + x as shift-add; only in-range coordinates ever reach memory
    function automatic logic [18:0] lin_addr(input logic [8:0] y, input logic [9:0] x);
        return {1'b0, y, 9'b0} + {3'b0, y, 7'b0} + {9'b0, x};
    endfunction

    assign disp_req   = (pix_x < PIX_H_LIM) && (pix_y < PIX_V_LIM);
    assign fifo_empty = (count == '0);
    assign wr_ready   = (count != CW'(WR_FIFO_DEPTH));
    assign push       = wr_valid && wr_ready;
    assign pop        = !disp_req && !fifo_empty;
    assign head_x     = fifo_mem[rd_ptr][34:25];
    assign head_y     = fifo_mem[rd_ptr][24:16];
    assign head_data  = fifo_mem[rd_ptr][15:0];
    assign vs_rise    = vsync && !vsync_d;
    assign pix_data   = rd_flag ? mem_rdata : 16'h0000;

    always_comb begin
        mem_en    = 1'b0;
        mem_we    = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        if (disp_req) begin
            mem_en   = 1'b1;
            mem_addr = {front_sel, lin_addr(pix_y[8:0], pix_x[9:0])};
        end else if (pop && (head_x < WR_H_LIM) && (head_y < WR_V_LIM)) begin
            mem_en    = 1'b1;
            mem_we    = 1'b1;
            mem_addr  = {~front_sel, lin_addr(head_y, head_x)};
            mem_wdata = head_data;
        end
    end

    always_ff @(posedge vga_clk) begin
        if (push) begin
            fifo_mem[wr_ptr] <= {wr_x, wr_y, wr_data};
        end
    end

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (push && !pop) begin
                count <= count + 1'b1;
            end else if (pop && !push) begin
                count <= count - 1'b1;
            end
        end
    end

    // A swap waits for a vsync edge seen with nothing left in flight for the old back buffer
    always_comb begin
        state_nxt = state;
        swap_fire = 1'b0;
        case (state)
            SWAP_IDLE: begin
                if (swap_req) begin
                    state_nxt = SWAP_PENDING;
                end
            end
            SWAP_PENDING: begin
                if (vs_rise && fifo_empty) begin
                    swap_fire = 1'b1;
                    state_nxt = swap_req ? SWAP_PENDING : SWAP_IDLE;
                end
            end
            default: state_nxt = SWAP_IDLE;
        endcase
    end

    assign swap_pending = (state == SWAP_PENDING);
    assign swap_done    = swap_fire;

    always_ff @(posedge vga_clk or posedge sys_rst) begin
        if (sys_rst) begin
            state     <= SWAP_IDLE;
            front_sel <= 1'b0;
            vsync_d   <= 1'b0;
            rd_flag   <= 1'b0;
        end else begin
            state   <= state_nxt;
            vsync_d <= vsync;
            rd_flag <= disp_req;
            if (swap_fire) begin
                front_sel <= ~front_sel;
            end
        end
    end

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// tb/tb_vga_fb_arbiter.sv - directed self-checking bench for vga_fb_arbiter
module tb_vga_fb_arbiter;

    logic        vga_clk;
    logic        sys_rst;
    logic [10:0] pix_x;
    logic [10:0] pix_y;
    logic        vsync;
    logic [15:0] pix_data;
    logic        wr_valid;
    logic        wr_ready;
    logic [9:0]  wr_x;
    logic [8:0]  wr_y;
    logic [15:0] wr_data;
    logic        swap_req;
    logic        swap_pending;
    logic        swap_done;
    logic        front_sel;
    logic        mem_en;
    logic        mem_we;
    logic [19:0] mem_addr;
    logic [15:0] mem_wdata;
    logic [15:0] mem_rdata;

    int n_checks = 0;
    int n_fails  = 0;

    vga_fb_arbiter #(
        .H_VALID(640),
        .V_VALID(480),
        .WR_FIFO_DEPTH(4)
    ) dut (
        .vga_clk(vga_clk),
        .sys_rst(sys_rst),
        .pix_x(pix_x),
        .pix_y(pix_y),
        .vsync(vsync),
        .pix_data(pix_data),
        .wr_valid(wr_valid),
        .wr_ready(wr_ready),
        .wr_x(wr_x),
        .wr_y(wr_y),
        .wr_data(wr_data),
        .swap_req(swap_req),
        .swap_pending(swap_pending),
        .swap_done(swap_done),
        .front_sel(front_sel),
        .mem_en(mem_en),
        .mem_we(mem_we),
        .mem_addr(mem_addr),
        .mem_wdata(mem_wdata),
        .mem_rdata(mem_rdata)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge vga_clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic check_write(input string tag, input logic [19:0] addr, input logic [15:0] data);
        check({tag, " en"}, 32'(mem_en), 32'd1);
        check({tag, " we"}, 32'(mem_we), 32'd1);
        check({tag, " addr"}, 32'(mem_addr), 32'(addr));
        check({tag, " wdata"}, 32'(mem_wdata), 32'(data));
    endtask

    task automatic set_wr(input logic v, input logic [9:0] x, input logic [8:0] y, input logic [15:0] d);
        wr_valid = v;
        wr_x     = x;
        wr_y     = y;
        wr_data  = d;
    endtask

    initial begin
        sys_rst   = 1'b1;
        pix_x     = 11'h3FF;
        pix_y     = 11'h3FF;
        vsync     = 1'b0;
        swap_req  = 1'b0;
        mem_rdata = 16'h1234;
        set_wr(1'b0, 10'd0, 9'd0, 16'h0);
        tick();
        tick();
        settle();
        check("rst pix_data", 32'(pix_data), 32'h0);
        check("rst front_sel", 32'(front_sel), 32'd0);
        check("rst swap_pending", 32'(swap_pending), 32'd0);
        check("rst swap_done", 32'(swap_done), 32'd0);
        check("rst wr_ready", 32'(wr_ready), 32'd1);
        check("rst mem_en", 32'(mem_en), 32'd0);
        sys_rst = 1'b0;
        tick();

        // display read at origin, pixel one cycle later
        pix_x = 11'd0;
        pix_y = 11'd0;
        settle();
        check("rd0 en", 32'(mem_en), 32'd1);
        check("rd0 we", 32'(mem_we), 32'd0);
        check("rd0 addr", 32'(mem_addr), 32'h00000);
        tick();
        pix_x = 11'h3FF;
        pix_y = 11'h3FF;
        mem_rdata = 16'hF800;
        settle();
        check("rd0 pix_data", 32'(pix_data), 32'hF800);
        check("idle en", 32'(mem_en), 32'd0);
        tick();
        settle();
        check("idle pix_data", 32'(pix_data), 32'h0);

        // last pixel in front buffer 0
        pix_x = 11'd639;
        pix_y = 11'd479;
        settle();
        check("rd last fs0 addr", 32'(mem_addr), 32'h4AFFF);
        tick();
        pix_x = 11'h3FF;
        pix_y = 11'h3FF;

        // swap with empty FIFO
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        settle();
        check("swap pending set", 32'(swap_pending), 32'd1);
        tick();
        tick();
        settle();
        check("swap still pending", 32'(swap_pending), 32'd1);
        check("swap not yet", 32'(front_sel), 32'd0);
        vsync = 1'b1;
        settle();
        check("swap_done on edge", 32'(swap_done), 32'd1);
        tick();
        settle();
        check("front_sel toggled", 32'(front_sel), 32'd1);
        check("swap_done one cycle", 32'(swap_done), 32'd0);
        check("swap pending clear", 32'(swap_pending), 32'd0);
        vsync = 1'b0;

        pix_x = 11'd639;
        pix_y = 11'd479;
        settle();
        check("rd last fs1 addr", 32'(mem_addr), 32'hCAFFF);
        check("rd last fs1 we", 32'(mem_we), 32'd0);
        tick();

        // five pushes during active video, depth 4
        pix_x = 11'd10;
        pix_y = 11'd10;
        set_wr(1'b1, 10'd1, 9'd0, 16'hA001);
        settle();
        check("push1 ready", 32'(wr_ready), 32'd1);
        tick();
        set_wr(1'b1, 10'd2, 9'd0, 16'hA002);
        tick();
        set_wr(1'b1, 10'd3, 9'd1, 16'hA003);
        tick();
        set_wr(1'b1, 10'd4, 9'd1, 16'hA004);
        settle();
        check("push4 ready", 32'(wr_ready), 32'd1);
        check("active no write", 32'(mem_we), 32'd0);
        tick();
        set_wr(1'b1, 10'd5, 9'd1, 16'hA005);
        settle();
        check("full ready low", 32'(wr_ready), 32'd0);
        check("full no write", 32'(mem_we), 32'd0);
        tick();
        set_wr(1'b0, 10'd0, 9'd0, 16'h0);
        pix_x = 11'h3FF;
        pix_y = 11'h3FF;
        settle();
        check_write("drain1", 20'h00001, 16'hA001);
        check("pop keeps ready low", 32'(wr_ready), 32'd0);
        tick();
        settle();
        check_write("drain2", 20'h00002, 16'hA002);
        tick();
        settle();
        check_write("drain3", 20'h00283, 16'hA003);
        tick();
        settle();
        check_write("drain4", 20'h00284, 16'hA004);
        tick();
        settle();
        check("drained en", 32'(mem_en), 32'd0);
        check("drained ready", 32'(wr_ready), 32'd1);

        // out-of-range entry accepted then dropped
        set_wr(1'b1, 10'd700, 9'd3, 16'hBEEF);
        settle();
        check("oob push ready", 32'(wr_ready), 32'd1);
        tick();
        set_wr(1'b0, 10'd0, 9'd0, 16'h0);
        settle();
        check("oob pop no en", 32'(mem_en), 32'd0);
        tick();
        settle();
        check("oob after no en", 32'(mem_en), 32'd0);

        // deferred swap: two writes stuck behind active video at the vsync edge
        pix_x = 11'd10;
        pix_y = 11'd10;
        set_wr(1'b1, 10'd5, 9'd2, 16'hB005);
        tick();
        set_wr(1'b1, 10'd6, 9'd2, 16'hB006);
        tick();
        set_wr(1'b0, 10'd0, 9'd0, 16'h0);
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        vsync = 1'b1;
        settle();
        check("defer no swap_done", 32'(swap_done), 32'd0);
        tick();
        pix_x = 11'h3FF;
        pix_y = 11'h3FF;
        settle();
        check("defer front_sel", 32'(front_sel), 32'd1);
        check("defer pending", 32'(swap_pending), 32'd1);
        check_write("ddrain1", 20'h00505, 16'hB005);
        tick();
        settle();
        check_write("ddrain2", 20'h00506, 16'hB006);
        tick();
        settle();
        check("vsync high no swap", 32'(swap_done), 32'd0);
        vsync = 1'b0;
        tick();
        tick();
        vsync = 1'b1;
        settle();
        check("next frame swap_done", 32'(swap_done), 32'd1);
        tick();
        settle();
        check("next frame front_sel", 32'(front_sel), 32'd0);
        check("next frame pending", 32'(swap_pending), 32'd0);
        vsync = 1'b0;
        tick();

        // new request in the same cycle a swap executes
        swap_req = 1'b1;
        tick();
        swap_req = 1'b0;
        tick();
        vsync = 1'b1;
        swap_req = 1'b1;
        settle();
        check("rearm swap_done", 32'(swap_done), 32'd1);
        tick();
        swap_req = 1'b0;
        settle();
        check("rearm front_sel", 32'(front_sel), 32'd1);
        check("rearm pending", 32'(swap_pending), 32'd1);
        tick();
        settle();
        check("rearm no repeat", 32'(swap_done), 32'd0);
        vsync = 1'b0;
        tick();

        // reset mid-drain
        pix_x = 11'd10;
        pix_y = 11'd10;
        set_wr(1'b1, 10'd7, 9'd0, 16'hC007);
        tick();
        set_wr(1'b1, 10'd8, 9'd0, 16'hC008);
        tick();
        set_wr(1'b0, 10'd0, 9'd0, 16'h0);
        pix_x = 11'h3FF;
        pix_y = 11'h3FF;
        settle();
        check_write("pre-rst drain", 20'h00007, 16'hC007);
        tick();
        sys_rst = 1'b1;
        settle();
        check("mid rst en", 32'(mem_en), 32'd0);
        check("mid rst ready", 32'(wr_ready), 32'd1);
        check("mid rst front_sel", 32'(front_sel), 32'd0);
        check("mid rst pending", 32'(swap_pending), 32'd0);
        tick();
        sys_rst = 1'b0;
        tick();
        settle();
        check("post rst fifo lost", 32'(mem_en), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
